// File: rtl/srs_rotation_ctrl_pkg.sv
// Shared game types and SRS wall-kick tables.
// Imported by the rotation engine and its kick lookup.
package srs_rotation_ctrl_pkg;

   typedef enum logic [2:0] {
      I, O, T, J, L, S, Z
   } tetromino_t;

   typedef enum logic [1:0] {
      ORIENTATION_0,
      ORIENTATION_R,
      ORIENTATION_2,
      ORIENTATION_L
   } orientation_t;

   typedef enum logic {
      DIR_CW,
      DIR_CCW
   } dir_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } rot_state_t;

   localparam logic [2:0] KICK_LAST   = 3'd4;
   localparam logic [2:0] KICK_LAST_O = 3'd0;

   // Rows indexed by {from, dir}: 0CW 0CCW RCW RCCW 2CW 2CCW LCW LCCW.
   // Offsets are (dx +right, dy +up), one column per test k.
   localparam int KICK_JLSTZ_DX [8][5] = '{
      '{0, -1, -1,  0, -1},
      '{0,  1,  1,  0,  1},
      '{0,  1,  1,  0,  1},
      '{0,  1,  1,  0,  1},
      '{0,  1,  1,  0,  1},
      '{0, -1, -1,  0, -1},
      '{0, -1, -1,  0, -1},
      '{0, -1, -1,  0, -1}
   };

   localparam int KICK_JLSTZ_DY [8][5] = '{
      '{0,  0,  1, -2, -2},
      '{0,  0,  1, -2, -2},
      '{0,  0, -1,  2,  2},
      '{0,  0, -1,  2,  2},
      '{0,  0,  1, -2, -2},
      '{0,  0,  1, -2, -2},
      '{0,  0, -1,  2,  2},
      '{0,  0, -1,  2,  2}
   };

   localparam int KICK_I_DX [8][5] = '{
      '{0, -2,  1, -2,  1},
      '{0, -1,  2, -1,  2},
      '{0, -1,  2, -1,  2},
      '{0,  2, -1,  2, -1},
      '{0,  2, -1,  2, -1},
      '{0,  1, -2,  1, -2},
      '{0,  1, -2,  1, -2},
      '{0, -2,  1, -2,  1}
   };

   localparam int KICK_I_DY [8][5] = '{
      '{0,  0,  0, -1,  2},
      '{0,  0,  0,  2, -1},
      '{0,  0,  0,  2, -1},
      '{0,  0,  0,  1, -2},
      '{0,  0,  0,  1, -2},
      '{0,  0,  0, -2,  1},
      '{0,  0,  0, -2,  1},
      '{0,  0,  0, -1,  2}
   };

   function automatic logic [2:0] kick_row(
      orientation_t from_o,
      dir_t         dir
   );
      return {from_o, dir};
   endfunction

   // 2-bit wrap gives the mod-4 step in both directions.
   function automatic orientation_t rotate_orient(
      orientation_t from_o,
      dir_t         dir
   );
      logic [1:0] r;
      if (dir == DIR_CW) begin
         r = from_o + 2'd1;
      end else begin
         r = from_o - 2'd1;
      end
      return orientation_t'(r);
   endfunction

endpackage

// File: rtl/srs_rotation_ctrl_kick.sv
// srs_kick_lut: combinational wall-kick offset lookup.
// In: piece_type, from_orient, dir, k. Out: signed dx (+right), dy (+up).
module srs_kick_lut
   import srs_rotation_ctrl_pkg::*;
(
   input  tetromino_t         piece_type,
   input  orientation_t       from_orient,
   input  dir_t               dir,
   input  logic [2:0]         k,
   output logic signed [3:0]  dx,
   output logic signed [3:0]  dy
);

   logic [2:0] row;

   always_comb begin
      dx  = '0;
      dy  = '0;
      row = kick_row(from_orient, dir);
      // O never kicks; k beyond the table yields no offset.
      if (piece_type != O && k <= KICK_LAST) begin
         if (piece_type == I) begin
            dx = 4'(KICK_I_DX[row][k]);
            dy = 4'(KICK_I_DY[row][k]);
         end else begin
            dx = 4'(KICK_JLSTZ_DX[row][k]);
            dy = 4'(KICK_JLSTZ_DY[row][k]);
         end
      end
   end

endmodule

// File: rtl/srs_rotation_ctrl.sv
// srs_rotation_ctrl: sequential SRS rotation engine with wall kicks.
// Ports: rotate_R/L + cur_* in; chk_* handshake to checker; rot_done/new_* out.
module srs_rotation_ctrl
   import srs_rotation_ctrl_pkg::*;
#(
   parameter int COORD_W = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rotate_R,
   input  logic                       rotate_L,
   input  tetromino_t                 piece_type,
   input  orientation_t               cur_orientation,
   input  logic signed [COORD_W-1:0]  cur_x,
   input  logic signed [COORD_W-1:0]  cur_y,
   output logic                       chk_req,
   output orientation_t               chk_orientation,
   output logic signed [COORD_W-1:0]  chk_x,
   output logic signed [COORD_W-1:0]  chk_y,
   input  logic                       chk_ack,
   input  logic                       chk_hit,
   output logic                       busy,
   output logic                       rot_done,
   output logic                       rot_success,
   output orientation_t               new_orientation,
   output logic signed [COORD_W-1:0]  new_x,
   output logic signed [COORD_W-1:0]  new_y
);

   rot_state_t state, state_nx;

   tetromino_t                lat_type, lat_type_nx;
   orientation_t              lat_orient, lat_orient_nx;
   dir_t                      lat_dir, lat_dir_nx;
   logic signed [COORD_W-1:0] lat_x, lat_x_nx;
   logic signed [COORD_W-1:0] lat_y, lat_y_nx;
   logic [2:0]                k, k_nx;
   logic                      ok, ok_nx;

   logic                      chk_req_nx;
   orientation_t              chk_orientation_nx;
   logic signed [COORD_W-1:0] chk_x_nx, chk_y_nx;
   logic                      busy_nx;
   logic                      rot_done_nx;
   logic                      rot_success_nx;
   orientation_t              new_orientation_nx;
   logic signed [COORD_W-1:0] new_x_nx, new_y_nx;

   logic signed [3:0]         dx, dy;
   logic signed [COORD_W-1:0] dx_ext, dy_ext;
   logic signed [COORD_W-1:0] cand_x, cand_y;
   orientation_t              tgt;
   logic [2:0]                k_last;

   srs_kick_lut u_kick (
      .piece_type  (lat_type),
      .from_orient (lat_orient),
      .dir         (lat_dir),
      .k           (k),
      .dx          (dx),
      .dy          (dy)
   );

   assign dx_ext = {{(COORD_W-4){dx[3]}}, dx};
   assign dy_ext = {{(COORD_W-4){dy[3]}}, dy};
   // Kick dy is +up while board rows grow downward.
   assign cand_x = lat_x + dx_ext;
   assign cand_y = lat_y - dy_ext;
   assign tgt    = rotate_orient(lat_orient, lat_dir);
   assign k_last = (lat_type == O) ? KICK_LAST_O : KICK_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx           = state;
      lat_type_nx        = lat_type;
      lat_orient_nx      = lat_orient;
      lat_dir_nx         = lat_dir;
      lat_x_nx           = lat_x;
      lat_y_nx           = lat_y;
      k_nx               = k;
      ok_nx              = ok;
      chk_req_nx         = chk_req;
      chk_orientation_nx = chk_orientation;
      chk_x_nx           = chk_x;
      chk_y_nx           = chk_y;
      busy_nx            = busy;
      rot_done_nx        = 1'b0;
      rot_success_nx     = rot_success;
      new_orientation_nx = new_orientation;
      new_x_nx           = new_x;
      new_y_nx           = new_y;

      unique case (state)
         IDLE: begin
            if (rotate_R ^ rotate_L) begin
               lat_type_nx   = piece_type;
               lat_orient_nx = cur_orientation;
               lat_dir_nx    = rotate_R ? DIR_CW : DIR_CCW;
               lat_x_nx      = cur_x;
               lat_y_nx      = cur_y;
               k_nx          = 3'd0;
               state_nx      = REQ;
            end
         end
         REQ: begin
            chk_req_nx         = 1'b1;
            busy_nx            = 1'b1;
            chk_orientation_nx = tgt;
            chk_x_nx           = cand_x;
            chk_y_nx           = cand_y;
            state_nx           = WAIT;
         end
         WAIT: begin
            if (chk_ack && chk_req) begin
               chk_req_nx = 1'b0;
               if (!chk_hit) begin
                  ok_nx    = 1'b1;
                  state_nx = DONE;
               end else if (k == k_last) begin
                  ok_nx    = 1'b0;
                  state_nx = DONE;
               end else begin
                  k_nx     = k + 3'd1;
                  state_nx = REQ;
               end
            end
         end
         DONE: begin
            // chk_* still hold the last candidate here.
            rot_done_nx    = 1'b1;
            busy_nx        = 1'b0;
            rot_success_nx = ok;
            if (ok) begin
               new_orientation_nx = chk_orientation;
               new_x_nx           = chk_x;
               new_y_nx           = chk_y;
            end else begin
               new_orientation_nx = lat_orient;
               new_x_nx           = lat_x;
               new_y_nx           = lat_y;
            end
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_type        <= I;
         lat_orient      <= ORIENTATION_0;
         lat_dir         <= DIR_CW;
         lat_x           <= '0;
         lat_y           <= '0;
         k               <= '0;
         ok              <= 1'b0;
         chk_req         <= 1'b0;
         chk_orientation <= ORIENTATION_0;
         chk_x           <= '0;
         chk_y           <= '0;
         busy            <= 1'b0;
         rot_done        <= 1'b0;
         rot_success     <= 1'b0;
         new_orientation <= ORIENTATION_0;
         new_x           <= '0;
         new_y           <= '0;
      end else begin
         lat_type        <= lat_type_nx;
         lat_orient      <= lat_orient_nx;
         lat_dir         <= lat_dir_nx;
         lat_x           <= lat_x_nx;
         lat_y           <= lat_y_nx;
         k               <= k_nx;
         ok              <= ok_nx;
         chk_req         <= chk_req_nx;
         chk_orientation <= chk_orientation_nx;
         chk_x           <= chk_x_nx;
         chk_y           <= chk_y_nx;
         busy            <= busy_nx;
         rot_done        <= rot_done_nx;
         rot_success     <= rot_success_nx;
         new_orientation <= new_orientation_nx;
         new_x           <= new_x_nx;
         new_y           <= new_y_nx;
      end
   end

endmodule

// File: doc/srs_rotation_ctrl.md
# srs_rotation_ctrl

Sequential rotation engine for the active tetromino under SRS. On a rotate request it walks the 5-entry wall-kick sequence from the shared game package, issuing one candidate placement per test to the collision checker. It commits the first non-colliding candidate, or reports failure if all candidates collide. It sits between the input/gravity control logic (upstream) and the board collision checker (downstream), and its result feeds the active-piece register.

## Interface
Parameters:
- COORD_W, 6: signed width of piece origin coordinates.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous, active-high reset.
- rotate_R  in  1: clockwise rotate request pulse.
- rotate_L  in  1: counter-clockwise rotate request pulse.
- piece_type  in  tetromino_t: type of the active piece.
- cur_orientation  in  orientation_t: current orientation.
- cur_x  in  COORD_W signed: origin column (+ rightward).
- cur_y  in  COORD_W signed: origin row (+ downward).
- chk_req  out  1: candidate valid; held until chk_ack.
- chk_orientation  out  orientation_t: candidate orientation.
- chk_x, chk_y  out  COORD_W signed: candidate origin.
- chk_ack  in  1: checker result valid this cycle.
- chk_hit  in  1: candidate collides or is out of bounds; qualified by chk_ack.
- busy  out  1: rotation in progress.
- rot_done  out  1: one-cycle completion pulse.
- rot_success  out  1: kick found; valid with rot_done, held until the next rot_done.
- new_orientation  out  orientation_t; new_x, new_y  out  COORD_W signed: resulting placement, held until the next rot_done.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Exactly one of rotate_R/rotate_L high → latch piece_type, cur_* and direction; kick index k=0; go to REQ.
  - Both high or neither high → stay in IDLE.
- Target orientation: R → (cur+1) mod 4; L → (cur−1) mod 4, using 2-bit wrap.
- Kick table is selected by (from, to) pair and I/non-I class.
- O piece: only k=0 is tested, with offset (0,0).
- Candidate: chk_x = cur_x + dx[k]; chk_y = cur_y − dy[k]. Table dy is +up, board y is +down.
  - Arithmetic is signed COORD_W with no saturation; bounds checking belongs to the checker.
- REQ: assert chk_req with the candidate, go to WAIT.
- WAIT: hold chk_req and the candidate stable until chk_ack.
  - chk_ack & !chk_hit → success; capture candidate into new_*; go to DONE.
  - chk_ack & chk_hit & k<last → k++; drop chk_req for one cycle; go to REQ.
  - chk_ack & chk_hit & k=last → failure; new_* = latched cur_*; go to DONE.
  - last = 4, or 0 for O.
- DONE: pulse rot_done with rot_success; go to IDLE.
- Rotate requests while busy are dropped; there is no queueing.
- cur_* changes while busy are ignored, because the latched copies are used.

## Timing
- All outputs are registered.
- Reset values: chk_req=0, chk_x=chk_y=0, chk_orientation=ORIENTATION_0, busy=0, rot_done=0, rot_success=0, new_x=new_y=0, new_orientation=ORIENTATION_0.
- Request sampled at edge t → busy=1 and chk_req=1 from t+1.
- With a checker acking in the cycle after the request is seen, each test costs 2 cycles.
  - Success on test k → rot_done visible 2k+3 cycles after t.
  - Worst case, 5 tests → rot_done at t+11.
- busy falls in the same cycle rot_done is asserted, so a new request can be accepted in the cycle after rot_done.
- chk_ack while chk_req=0 is ignored.
- rst at any cycle → IDLE on the next edge.
  - chk_req, busy and rot_done are low the following cycle.
  - No rot_done is issued for an aborted rotation.

## Structure
- GamePkg additions:
  - tetromino_t enum {I, O, T, J, L, S, Z}.
  - Direction type (CW/CCW).
  - Kick tables stay in GamePkg.
- Sub-module srs_kick_lut (combinational): (piece_type, from orientation, direction, k) → signed dx, dy from the GamePkg tables, with O forced to (0,0).
- srs_rotation_ctrl contains the FSM, latches, k counter and output registers.

## Test plan
1. T at (4,10), ORIENTATION_0, rotate_R, checker never hits → one check at (4,10,R); rot_done at t+3; success=1; new=(4,10,R).
2. J at (4,10), ORIENTATION_0, rotate_R, hits on k=0,1 → k=2 checked at (3,9,R); success; new=(3,9,R).
3. I at (5,5), ORIENTATION_R, rotate_L, all 5 hit → checks in order:
   - (7,5), (4,5)?? no — exact order: (5,5), (7,5), (4,5), (7,4), (4,7), all at ORIENTATION_0.
   - rot_done at t+11; success=0; new=(5,5,R).
4. O at (4,0), ORIENTATION_L, rotate_R with hit → exactly one check at (4,0,0); failure reported after that single test.
5. rotate_R and rotate_L asserted together → no chk_req, busy stays 0. A rotate pulse during WAIT is ignored, and exactly one rot_done results.
6. rst asserted while in WAIT → next cycle chk_req=busy=0; no rot_done; a fresh rotate_R afterwards completes normally.
